// File: rtl/eth_axis_pkg.sv
// Shared types and helpers for the Ethernet AXI-Stream width converters.
package eth_axis_pkg;

    localparam int MAX_BYTES = 16;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } upsizer_state_t;

    // Width of a lane counter; a one-lane counter still needs one bit.
    function automatic int lane_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

    // Lane-valid mask for a word holding k bytes; callers take the low `bytes` bits.
    function automatic logic [MAX_BYTES-1:0] keep_mask(input int k, input int bytes,
                                                       input bit big_endian);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (big_endian)
                m[i] = (i < bytes) && (i >= bytes - k);
            else
                m[i] = (i < k);
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word fall-through synchronous FIFO; output reads as zero while empty.
module axis_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_wr;
    logic             do_rd;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign do_rd     = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO may still take a write.
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_wr)
            mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/axis_upsizer_8_n.sv
// Packs an 8-bit AXI-Stream into BYTES-wide words with tkeep on the final partial word,
// buffering completed words in a FWFT FIFO.
module axis_upsizer_8_n
    import eth_axis_pkg::*;
#(
    parameter int BYTES      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int BIG_ENDIAN = 1,
    localparam int DATA_W    = 8 * BYTES
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [BYTES-1:0]  m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [15:0]       frame_count
);
    localparam int LANE_W = lane_width(BYTES);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WORD_W = DATA_W + BYTES + 1;

    upsizer_state_t       state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d, lane_idx;
    logic [DATA_W-1:0]    acc_q, acc_d, word_fill;
    logic [BYTES-1:0]     keep_q, keep_d, fill_keep;
    logic                 last_q, last_d;
    logic                 tready_q, tready_d;
    logic [15:0]          frame_q, frame_d;
    logic [MAX_BYTES-1:0] fill_mask;
    logic                 accept, complete, can_push, push, pop;
    logic [WORD_W-1:0]    push_word, pop_word;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count, count_next;

    assign s_axis_tready = tready_q;
    assign frame_count   = frame_q;
    assign accept        = s_axis_tvalid && tready_q;
    assign complete      = accept && ((lane_q == LANE_W'(BYTES - 1)) || s_axis_tlast);
    assign lane_idx      = (BIG_ENDIAN != 0) ? (LANE_W'(BYTES - 1) - lane_q) : lane_q;
    assign fill_mask     = keep_mask(int'(lane_q) + 1, BYTES, BIG_ENDIAN != 0);
    assign fill_keep     = fill_mask[BYTES-1:0];

    generate
        if (BYTES < MAX_BYTES) begin : g_keep_spare
            logic keep_unused;
            assign keep_unused = ^fill_mask[MAX_BYTES-1:BYTES];
        end
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            assign word_fill[8*gi +: 8] = (lane_idx == LANE_W'(gi)) ? s_axis_tdata
                                                                     : acc_q[8*gi +: 8];
        end
    endgenerate

    assign pop      = !fifo_empty && m_axis_tready;
    assign can_push = !fifo_full || pop;

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        acc_d     = acc_q;
        keep_d    = keep_q;
        last_d    = last_q;
        push      = 1'b0;
        push_word = {last_q, keep_q, acc_q};
        unique case (state_q)
            FILL: begin
                if (complete) begin
                    lane_d = '0;
                    if (can_push) begin
                        push      = 1'b1;
                        push_word = {s_axis_tlast, fill_keep, word_fill};
                        acc_d     = '0;
                    end else begin
                        // Hold the finished word and retry next cycle instead of dropping it.
                        acc_d   = word_fill;
                        keep_d  = fill_keep;
                        last_d  = s_axis_tlast;
                        state_d = FLUSH;
                    end
                end else if (accept) begin
                    acc_d  = word_fill;
                    lane_d = lane_q + LANE_W'(1);
                end
            end
            FLUSH: begin
                if (can_push) begin
                    push    = 1'b1;
                    acc_d   = '0;
                    keep_d  = '0;
                    last_d  = 1'b0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Ready looks at next-cycle occupancy so a word never completes into a full FIFO.
    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign tready_d   = (count_next != CNT_W'(FIFO_DEPTH)) && (state_d == FILL);
    assign frame_d    = frame_q + 16'(pop && m_axis_tlast);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= FILL;
            lane_q   <= '0;
            acc_q    <= '0;
            keep_q   <= '0;
            last_q   <= 1'b0;
            tready_q <= 1'b0;
            frame_q  <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            acc_q    <= acc_d;
            keep_q   <= keep_d;
            last_q   <= last_d;
            tready_q <= tready_d;
            frame_q  <= frame_d;
        end
    end

    axis_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (aclk),
        .rst_i     (areset),
        .wr_en_i   (push),
        .wr_data_i (push_word),
        .rd_en_i   (m_axis_tready),
        .rd_data_o (pop_word),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = pop_word;
    assign m_axis_tvalid = !fifo_empty;

endmodule

// File: tb/tb_axis_upsizer_8_n.sv
// Directed and randomised checks of the byte-to-word upsizer in three configurations.
`timescale 1ns/1ps
module tb_axis_upsizer_8_n;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready0, s_tready1, s_tready2;
    logic        mready0 = 1'b1, mready1 = 1'b1, mready2 = 1'b1;

    logic [31:0] d0_data;  logic [3:0] d0_keep;  logic d0_valid, d0_last;  logic [15:0] d0_fc;
    logic [63:0] d1_data;  logic [7:0] d1_keep;  logic d1_valid, d1_last;  logic [15:0] d1_fc;
    logic [31:0] d2_data;  logic [3:0] d2_keep;  logic d2_valid, d2_last;  logic [15:0] d2_fc;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [36:0] q0[$];
    int          q0_cyc[$];
    logic [72:0] q1[$];
    logic [36:0] q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BYTES=4, big-endian, depth 8
    axis_upsizer_8_n #(.BYTES(4), .FIFO_DEPTH(8), .BIG_ENDIAN(1)) dut0 (
        .aclk(clk), .areset(areset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready0), .m_axis_tdata(d0_data),
        .m_axis_tkeep(d0_keep), .m_axis_tvalid(d0_valid), .m_axis_tlast(d0_last),
        .m_axis_tready(mready0), .frame_count(d0_fc));

    // BYTES=8, little-endian
    axis_upsizer_8_n #(.BYTES(8), .FIFO_DEPTH(8), .BIG_ENDIAN(0)) dut1 (
        .aclk(clk), .areset(areset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready1), .m_axis_tdata(d1_data),
        .m_axis_tkeep(d1_keep), .m_axis_tvalid(d1_valid), .m_axis_tlast(d1_last),
        .m_axis_tready(mready1), .frame_count(d1_fc));

    // BYTES=4, big-endian, shallow FIFO for backpressure
    axis_upsizer_8_n #(.BYTES(4), .FIFO_DEPTH(4), .BIG_ENDIAN(1)) dut2 (
        .aclk(clk), .areset(areset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready2), .m_axis_tdata(d2_data),
        .m_axis_tkeep(d2_keep), .m_axis_tvalid(d2_valid), .m_axis_tlast(d2_last),
        .m_axis_tready(mready2), .frame_count(d2_fc));

    always @(negedge clk) begin
        if (!areset) begin
            if (d0_valid && mready0) begin
                q0.push_back({d0_data, d0_keep, d0_last});
                q0_cyc.push_back(cyc);
            end
            if (d1_valid && mready1) q1.push_back({d1_data, d1_keep, d1_last});
            if (d2_valid && mready2) q2.push_back({d2_data, d2_keep, d2_last});
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic rdy(input int sel);
        case (sel)
            0:       return s_tready0;
            1:       return s_tready1;
            default: return s_tready2;
        endcase
    endfunction

    task automatic do_reset();
        areset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        mready0 = 1'b1; mready1 = 1'b1; mready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the byte on the bus until the selected DUT takes it; returns the cycle of the handshake.
    task automatic send_byte(input int sel, input logic [7:0] d, input logic last, output int hs_cyc);
        bit done;
        done = 0;
        s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (rdy(sel)) done = 1;
            @(posedge clk); #1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_timeout: byte %02h to dut%0d never accepted", d, sel);
        end
        hs_cyc = cyc;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        #1;
        tests++; if (d0_valid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b want 0", d0_valid); end
        tests++; if (d0_data !== 32'h0) begin fails++; $display("FAIL reset_tdata: got %h want 0", d0_data); end
        tests++; if (d0_keep !== 4'h0 || d0_last !== 1'b0) begin fails++; $display("FAIL reset_keep_last: got %h/%b want 0/0", d0_keep, d0_last); end
        tests++; if (d0_fc !== 16'h0) begin fails++; $display("FAIL reset_fc: got %0d want 0", d0_fc); end
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
        @(negedge clk);
        tests++; if (s_tready0 !== 1'b0) begin fails++; $display("FAIL reset_tready_low: got %b want 0", s_tready0); end
        @(posedge clk); #1;
        tests++; if (s_tready0 !== 1'b1) begin fails++; $display("FAIL reset_tready_rise: got %b want 1", s_tready0); end
    endtask

    task automatic test_basic();
        int base, c, h;
        do_reset();
        base = q0.size();
        h = -1;
        for (int i = 1; i <= 8; i++) begin
            send_byte(0, 8'(i), i == 8, c);
            if (i == 4) h = c;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_cycles(6);
        tests++;
        if (q0.size() != base + 2) begin
            fails++; $display("FAIL basic_count: got %0d words want 2", q0.size() - base);
        end else begin
            tests++; if (q0[base] !== {32'h01020304, 4'hF, 1'b0}) begin fails++; $display("FAIL basic_w0: got %h want %h", q0[base], {32'h01020304, 4'hF, 1'b0}); end
            tests++; if (q0[base+1] !== {32'h05060708, 4'hF, 1'b1}) begin fails++; $display("FAIL basic_w1: got %h want %h", q0[base+1], {32'h05060708, 4'hF, 1'b1}); end
            tests++; if (q0_cyc[base] != h) begin fails++; $display("FAIL basic_latency: tvalid cycle %0d want %0d", q0_cyc[base], h); end
        end
        tests++; if (d0_fc !== 16'd1) begin fails++; $display("FAIL basic_fc: got %0d want 1", d0_fc); end
    endtask

    task automatic test_partial();
        int base, c;
        do_reset();
        base = q0.size();
        for (int i = 0; i < 6; i++) send_byte(0, 8'hA0 + 8'(i), i == 5, c);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_cycles(6);
        tests++;
        if (q0.size() != base + 2) begin
            fails++; $display("FAIL partial_count: got %0d words want 2", q0.size() - base);
        end else begin
            tests++; if (q0[base] !== {32'hA0A1A2A3, 4'hF, 1'b0}) begin fails++; $display("FAIL partial_w0: got %h want %h", q0[base], {32'hA0A1A2A3, 4'hF, 1'b0}); end
            tests++; if (q0[base+1] !== {32'hA4A50000, 4'hC, 1'b1}) begin fails++; $display("FAIL partial_w1: got %h want %h", q0[base+1], {32'hA4A50000, 4'hC, 1'b1}); end
        end
    endtask

    task automatic test_back_to_back();
        int base, c;
        do_reset();
        base = q0.size();
        send_byte(0, 8'h01, 1'b0, c);
        send_byte(0, 8'h02, 1'b0, c);
        send_byte(0, 8'h03, 1'b1, c);
        send_byte(0, 8'h04, 1'b0, c);
        send_byte(0, 8'h05, 1'b1, c);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_cycles(6);
        tests++;
        if (q0.size() != base + 2) begin
            fails++; $display("FAIL b2b_count: got %0d words want 2", q0.size() - base);
        end else begin
            tests++; if (q0[base] !== {32'h01020300, 4'hE, 1'b1}) begin fails++; $display("FAIL b2b_w0: got %h want %h", q0[base], {32'h01020300, 4'hE, 1'b1}); end
            tests++; if (q0[base+1] !== {32'h04050000, 4'hC, 1'b1}) begin fails++; $display("FAIL b2b_w1: got %h want %h", q0[base+1], {32'h04050000, 4'hC, 1'b1}); end
        end
        tests++; if (d0_fc !== 16'd2) begin fails++; $display("FAIL b2b_fc: got %0d want 2", d0_fc); end
    endtask

    task automatic test_le8();
        int base, c;
        do_reset();
        base = q1.size();
        send_byte(1, 8'h11, 1'b0, c);
        send_byte(1, 8'h22, 1'b0, c);
        send_byte(1, 8'h33, 1'b1, c);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_cycles(6);
        tests++;
        if (q1.size() != base + 1) begin
            fails++; $display("FAIL le8_count: got %0d words want 1", q1.size() - base);
        end else begin
            tests++; if (q1[base] !== {64'h0000000000332211, 8'h07, 1'b1}) begin fails++; $display("FAIL le8_word: got %h want %h", q1[base], {64'h0000000000332211, 8'h07, 1'b1}); end
        end
        tests++; if (d1_fc !== 16'd1) begin fails++; $display("FAIL le8_fc: got %0d want 1", d1_fc); end
    endtask

    task automatic test_backpressure();
        int base, idx, c;
        bit hs, stall_bad;
        logic [36:0] exp_w;
        do_reset();
        base = q2.size();
        mready2 = 1'b0;
        idx = 0; stall_bad = 0;
        s_tvalid = 1'b1; s_tdata = 8'(idx); s_tlast = 1'b0;
        for (c = 0; c < 30; c++) begin
            @(negedge clk);
            hs = s_tvalid && s_tready2;
            if (d2_valid && d2_data !== 32'h00010203) stall_bad = 1;
            @(posedge clk); #1;
            if (hs) begin idx++; s_tdata = 8'(idx); s_tlast = (idx == 39); end
        end
        tests++; if (idx != 16) begin fails++; $display("FAIL bp_accepted: got %0d bytes want 16", idx); end
        tests++; if (s_tready2 !== 1'b0) begin fails++; $display("FAIL bp_tready: got %b want 0", s_tready2); end
        tests++; if (stall_bad || d2_valid !== 1'b1) begin fails++; $display("FAIL bp_stable: head %h valid %b want 00010203 valid 1", d2_data, d2_valid); end
        mready2 = 1'b1;
        for (c = 0; c < 300 && idx < 40; c++) begin
            @(negedge clk);
            hs = s_tvalid && s_tready2;
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                if (idx == 40) s_tvalid = 1'b0;
                else begin s_tdata = 8'(idx); s_tlast = (idx == 39); end
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_cycles(20);
        tests++;
        if (q2.size() != base + 10) begin
            fails++; $display("FAIL bp_count: got %0d words want 10", q2.size() - base);
        end else begin
            for (int j = 0; j < 10; j++) begin
                exp_w = {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3), 4'hF, j == 9};
                tests++;
                if (q2[base+j] !== exp_w) begin fails++; $display("FAIL bp_word%0d: got %h want %h", j, q2[base+j], exp_w); end
            end
        end
        tests++; if (d2_fc !== 16'd1) begin fails++; $display("FAIL bp_fc: got %0d want 1", d2_fc); end
    endtask

    task automatic test_random();
        logic [7:0]  bytes[$];
        bit          lasts[$];
        logic [36:0] exp_q[$];
        logic [31:0] w;
        logic [3:0]  kp;
        logic [36:0] prev_w;
        int base, len, k, idx, nbad, stab_bad;
        bit hs, stall_prev;
        do_reset();
        base = q0.size();
        for (int f = 0; f < 200; f++) begin
            len = $urandom_range(1, 100);
            for (int b = 0; b < len; b++) begin
                bytes.push_back(8'($urandom));
                lasts.push_back(b == len - 1);
            end
        end
        k = 0; w = '0; kp = '0;
        for (int i = 0; i < bytes.size(); i++) begin
            w[8*(3-k) +: 8] = bytes[i];
            kp[3-k] = 1'b1;
            k++;
            if (k == 4 || lasts[i]) begin
                exp_q.push_back({w, kp, lasts[i]});
                k = 0; w = '0; kp = '0;
            end
        end
        idx = 0; stab_bad = 0; stall_prev = 0; prev_w = '0;
        for (int c = 0; c < 60000 && !(idx == bytes.size() && q0.size() - base == exp_q.size()); c++) begin
            mready0 = 1'($urandom_range(0, 1));
            if (!s_tvalid && idx < bytes.size() && $urandom_range(0, 1) == 1) begin
                s_tvalid = 1'b1; s_tdata = bytes[idx]; s_tlast = lasts[idx];
            end
            @(negedge clk);
            if (stall_prev && {d0_data, d0_keep, d0_last} !== prev_w) stab_bad++;
            stall_prev = d0_valid && !mready0;
            prev_w = {d0_data, d0_keep, d0_last};
            hs = s_tvalid && s_tready0;
            @(posedge clk); #1;
            if (hs) begin idx++; s_tvalid = 1'b0; s_tlast = 1'b0; end
        end
        mready0 = 1'b1; s_tvalid = 1'b0;
        tests++; if (idx != bytes.size()) begin fails++; $display("FAIL rnd_bytes: accepted %0d want %0d", idx, bytes.size()); end
        tests++;
        if (q0.size() - base != exp_q.size()) begin
            fails++; $display("FAIL rnd_count: got %0d words want %0d", q0.size() - base, exp_q.size());
        end else begin
            nbad = 0;
            for (int j = 0; j < exp_q.size(); j++) begin
                if (q0[base+j] !== exp_q[j]) begin
                    if (nbad < 5) $display("FAIL rnd_word%0d: got %h want %h", j, q0[base+j], exp_q[j]);
                    nbad++;
                end
            end
            tests++; if (nbad != 0) begin fails++; $display("FAIL rnd_words: %0d mismatched words want 0", nbad); end
        end
        tests++; if (stab_bad != 0) begin fails++; $display("FAIL rnd_stable: %0d stall changes want 0", stab_bad); end
        tests++; if (d0_fc !== 16'd200) begin fails++; $display("FAIL rnd_fc: got %0d want 200", d0_fc); end
    endtask

    task automatic test_reset_midframe();
        int base, c;
        do_reset();
        send_byte(0, 8'h55, 1'b0, c);
        send_byte(0, 8'h66, 1'b1, c);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_cycles(4);
        mready0 = 1'b0;
        for (int i = 0; i < 10; i++) send_byte(0, 8'hC0 + 8'(i), 1'b0, c);
        s_tvalid = 1'b0;
        wait_cycles(2);
        tests++; if (d0_valid !== 1'b1 || d0_fc !== 16'd1) begin fails++; $display("FAIL mid_pre: valid %b fc %0d want 1/1", d0_valid, d0_fc); end
        areset = 1'b1;
        #1;
        tests++; if ({d0_valid, d0_last, d0_keep, d0_data} !== 38'h0) begin fails++; $display("FAIL mid_outputs: got %h want 0", {d0_valid, d0_last, d0_keep, d0_data}); end
        tests++; if (s_tready0 !== 1'b0 || d0_fc !== 16'd0) begin fails++; $display("FAIL mid_ready_fc: tready %b fc %0d want 0/0", s_tready0, d0_fc); end
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
        @(posedge clk); #1;
        mready0 = 1'b1;
        base = q0.size();
        for (int i = 0; i < 4; i++) send_byte(0, 8'hB0 + 8'(i), i == 3, c);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_cycles(8);
        tests++;
        if (q0.size() != base + 1) begin
            fails++; $display("FAIL mid_count: got %0d words want 1", q0.size() - base);
        end else begin
            tests++; if (q0[base] !== {32'hB0B1B2B3, 4'hF, 1'b1}) begin fails++; $display("FAIL mid_word: got %h want %h", q0[base], {32'hB0B1B2B3, 4'hF, 1'b1}); end
        end
        tests++; if (d0_fc !== 16'd1) begin fails++; $display("FAIL mid_fc: got %0d want 1", d0_fc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_back_to_back();
        test_le8();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
